// File: rtl/cadss_ic_pkg.sv
// Shared interconnect definitions used by the injector, the bus and the completion side.
package cadss_ic_pkg;

    localparam int DEF_NUM_PROC = 8;
    localparam int DEF_ADDR_W   = 48;
    localparam int PROC_W       = $clog2(DEF_NUM_PROC);
    localparam int DEST_W       = PROC_W + 1;

    // One cache-transfer request as it travels toward the bus.
    typedef struct packed {
        logic [DEST_W-1:0]     dest;
        logic [DEF_ADDR_W-1:0] mem_address;
    } request_t;

    // Build a request from its fields.
    function automatic request_t make_request(input logic [DEST_W-1:0] dest,
                                              input logic [DEF_ADDR_W-1:0] addr);
        request_t r;
        r.dest        = dest;
        r.mem_address = addr;
        return r;
    endfunction

endpackage

// File: rtl/req_fifo.sv
// Single per-processor request queue: explicit-wrap pointers, registered count,
// zero-masked head, and a pop-while-empty indication for the sticky error.
module req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 52
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     avail,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     pop_ok,
    output logic                     underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wptr_reg;
    logic [PTR_W-1:0] rptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push_ok;

    // Pointer advance with explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign push_ok   = push && (count_reg != FULL_CNT);
    assign pop_ok    = pop && (count_reg != '0);
    assign underflow = pop && (count_reg == '0);

    // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push_ok) wptr_reg <= ptr_inc(wptr_reg);
            if (pop_ok)  rptr_reg <= ptr_inc(rptr_reg);
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) mem_reg[wptr_reg] <= push_data;
    end

    assign avail = (count_reg != '0);
    assign head  = avail ? mem_reg[rptr_reg] : '0;
    assign count = count_reg;

endmodule

// File: rtl/bus_request_injector.sv
// Per-processor request buffering ahead of the bus interconnect: routes each
// accepted request to its source queue and presents every queue head to the bus.
module bus_request_injector
    import cadss_ic_pkg::*;
#(
    parameter int NUM_PROC = DEF_NUM_PROC,
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     enq_valid,
    input  logic [$clog2(NUM_PROC)-1:0]              enq_src,
    input  logic [$clog2(NUM_PROC):0]                enq_dest,
    input  logic [ADDR_W-1:0]                        enq_addr,
    output logic                                     enq_ready,
    output logic [NUM_PROC-1:0]                      request_in_avail,
    output logic [NUM_PROC-1:0][$clog2(NUM_PROC):0]  request_dest,
    output logic [NUM_PROC-1:0][ADDR_W-1:0]          addrs_in,
    input  logic [NUM_PROC-1:0]                      processed_request,
    output logic [NUM_PROC-1:0][$clog2(DEPTH):0]     occupancy,
    output logic [$clog2(NUM_PROC*DEPTH):0]          total_in_flight,
    output logic                                     overflow_err,
    output logic                                     underflow_err
);

    localparam int SRC_W   = $clog2(NUM_PROC);
    localparam int DST_W   = SRC_W + 1;
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int TOT_W   = $clog2(NUM_PROC * DEPTH) + 1;
    // Entry layout matches request_t: {dest, mem_address}.
    localparam int ENTRY_W = DST_W + ADDR_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic                   enq_fire;
    logic [ENTRY_W-1:0]     enq_entry;
    logic [ENTRY_W-1:0]     head_w [NUM_PROC];
    logic [NUM_PROC-1:0]    push_w;
    logic [NUM_PROC-1:0]    pop_ok_w;
    logic [NUM_PROC-1:0]    underflow_w;
    logic [TOT_W-1:0]       pop_cnt;
    logic [TOT_W-1:0]       total_reg;
    logic [TOT_W-1:0]       total_next;
    logic                   overflow_reg;
    logic                   underflow_reg;

    assign enq_entry = {enq_dest, enq_addr};
    assign enq_fire  = enq_valid && enq_ready;

    // Ready reflects only the registered count of the addressed queue.
    always_comb begin
        enq_ready = 1'b0;
        if ({1'b0, enq_src} < DST_W'(NUM_PROC)) begin
            enq_ready = (occupancy[enq_src] != FULL_CNT);
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_PROC; gi++) begin : g_queue
            assign push_w[gi] = enq_fire && (enq_src == SRC_W'(gi));

            req_fifo #(
                .DEPTH (DEPTH),
                .WIDTH (ENTRY_W)
            ) u_fifo (
                .clk       (clk),
                .rst       (rst),
                .push      (push_w[gi]),
                .push_data (enq_entry),
                .pop       (processed_request[gi]),
                .head      (head_w[gi]),
                .avail     (request_in_avail[gi]),
                .count     (occupancy[gi]),
                .pop_ok    (pop_ok_w[gi]),
                .underflow (underflow_w[gi])
            );

            assign request_dest[gi] = head_w[gi][ENTRY_W-1 -: DST_W];
            assign addrs_in[gi]     = head_w[gi][ADDR_W-1:0];
        end
    endgenerate

    // Running total: one possible enqueue minus however many queues actually popped.
    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < NUM_PROC; i++) begin
            pop_cnt = pop_cnt + TOT_W'(pop_ok_w[i]);
        end
        total_next = total_reg + TOT_W'(enq_fire) - pop_cnt;
    end

    // Total occupancy register and sticky misuse flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            total_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            total_reg <= total_next;
            if (enq_valid && !enq_ready) overflow_reg  <= 1'b1;
            if (|underflow_w)            underflow_reg <= 1'b1;
        end
    end

    assign total_in_flight = total_reg;
    assign overflow_err    = overflow_reg;
    assign underflow_err   = underflow_reg;

endmodule

// File: tb/tb_bus_request_injector.sv
// Self-checking bench: per-queue scoreboard of expected requests, popped by a
// monitor whenever the bus retires a presented head; occupancy model checked each cycle.
module tb_bus_request_injector;
    import cadss_ic_pkg::*;

    localparam int NP    = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 48;
    localparam int SW    = 3;
    localparam int DW    = 4;
    localparam int CW    = 3;
    localparam int TW    = 6;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  enq_valid;
    logic [SW-1:0]         enq_src;
    logic [DW-1:0]         enq_dest;
    logic [AW-1:0]         enq_addr;
    logic                  enq_ready;
    logic [NP-1:0]         request_in_avail;
    logic [NP-1:0][DW-1:0] request_dest;
    logic [NP-1:0][AW-1:0] addrs_in;
    logic [NP-1:0]         processed_request;
    logic [NP-1:0][CW-1:0] occupancy;
    logic [TW-1:0]         total_in_flight;
    logic                  overflow_err;
    logic                  underflow_err;

    bus_request_injector #(.NUM_PROC(NP), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk               (clk),
        .rst               (rst),
        .enq_valid         (enq_valid),
        .enq_src           (enq_src),
        .enq_dest          (enq_dest),
        .enq_addr          (enq_addr),
        .enq_ready         (enq_ready),
        .request_in_avail  (request_in_avail),
        .request_dest      (request_dest),
        .addrs_in          (addrs_in),
        .processed_request (processed_request),
        .occupancy         (occupancy),
        .total_in_flight   (total_in_flight),
        .overflow_err      (overflow_err),
        .underflow_err     (underflow_err)
    );

    always #5 clk = ~clk;

    // Reference model: expected request order per queue plus plain occupancy counters.
    request_t exp_q [NP][$];
    int       mocc [NP];
    int       mtotal;
    bit       movf;
    bit       mudf;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every retired head must be the oldest outstanding request of that queue.
    always @(negedge clk) begin
        request_t e;
        if (rst === 1'b0) begin
            for (int i = 0; i < NP; i++) begin
                if (processed_request[i] && request_in_avail[i]) begin
                    if (exp_q[i].size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL spurious_head q%0d: got addr %0h expected no entry", i, addrs_in[i]);
                    end else begin
                        e = exp_q[i].pop_front();
                        check($sformatf("head_dest q%0d", i), 64'(request_dest[i]), 64'(e.dest));
                        check($sformatf("head_addr q%0d", i), 64'(addrs_in[i]), 64'(e.mem_address));
                    end
                end
            end
        end
    end

    // Compare registered state against the model (called just after a clock edge).
    task automatic state_check();
        for (int i = 0; i < NP; i++) begin
            check($sformatf("occupancy q%0d", i), 64'(occupancy[i]), 64'(mocc[i]));
            check($sformatf("avail q%0d", i), 64'(request_in_avail[i]), 64'(mocc[i] > 0));
            if (mocc[i] == 0) begin
                check($sformatf("empty_dest q%0d", i), 64'(request_dest[i]), 64'd0);
                check($sformatf("empty_addr q%0d", i), 64'(addrs_in[i]), 64'd0);
            end
        end
        check("total_in_flight", 64'(total_in_flight), 64'(mtotal));
        check("overflow_err", 64'(overflow_err), 64'(movf));
        check("underflow_err", 64'(underflow_err), 64'(mudf));
    endtask

    // One bus cycle: offer an optional enqueue and a pop vector, update the model, check.
    task automatic cycle(input bit ev, input int src, input logic [DW-1:0] dest,
                         input logic [AW-1:0] addr, input logic [NP-1:0] pops);
        bit acc;
        enq_valid         = ev;
        enq_src           = SW'(src);
        enq_dest          = dest;
        enq_addr          = addr;
        processed_request = pops;
        acc = ev && (mocc[src] < DEPTH);
        if (acc) exp_q[src].push_back(make_request(dest, addr));
        $display("[TB] t=%0t enq=%0b src=%0d dest=%0d addr=%0h pops=%02h accept=%0b",
                 $time, ev, src, dest, addr, pops, acc);
        @(negedge clk);
        check("enq_ready", 64'(enq_ready), 64'(mocc[src] < DEPTH));
        for (int i = 0; i < NP; i++) begin
            if (pops[i]) begin
                if (mocc[i] > 0) begin
                    mocc[i]--;
                    mtotal--;
                end else begin
                    mudf = 1'b1;
                end
            end
        end
        if (acc) begin
            mocc[src]++;
            mtotal++;
        end
        if (ev && !acc) movf = 1'b1;
        @(posedge clk);
        #1;
        state_check();
    endtask

    // Reset with traffic on the inputs; everything queued is discarded.
    task automatic do_reset();
        rst               = 1'b1;
        enq_valid         = 1'b1;
        enq_src           = 3'd2;
        enq_dest          = 4'd1;
        enq_addr          = 48'h55;
        processed_request = '1;
        $display("[TB] t=%0t reset asserted for 2 cycles", $time);
        repeat (2) @(posedge clk);
        #1;
        rst               = 1'b0;
        enq_valid         = 1'b0;
        processed_request = '0;
        for (int i = 0; i < NP; i++) begin
            exp_q[i].delete();
            mocc[i] = 0;
        end
        mtotal = 0;
        movf   = 1'b0;
        mudf   = 1'b0;
        state_check();
    endtask

    initial begin
        logic [AW-1:0] a;
        enq_src  = '0;
        enq_dest = '0;
        enq_addr = '0;
        do_reset();

        // Basic enqueue then retire.
        cycle(1, 3, 4'd5, 48'h1000, 8'h00);
        check("basic_avail", 64'(request_in_avail), 64'h08);
        check("basic_dest", 64'(request_dest[3]), 64'd5);
        check("basic_addr", 64'(addrs_in[3]), 64'h1000);
        cycle(0, 0, 4'd0, 48'h0, 8'h08);

        // Fill queue 0 past capacity, then drain in order.
        for (int k = 1; k <= 5; k++) cycle(1, 0, 4'(k), AW'(k * 16), 8'h00);
        for (int k = 0; k < 4; k++) cycle(0, 0, 4'd0, 48'h0, 8'h01);

        // Simultaneous enqueue and pop on queue 2.
        cycle(1, 2, 4'd9, 48'h100, 8'h00);
        cycle(1, 2, 4'd15, 48'h200, 8'h00);
        cycle(1, 2, 4'd2, 48'hA, 8'h04);
        for (int k = 0; k < 2; k++) cycle(0, 0, 4'd0, 48'h0, 8'h04);

        // Pops on every queue with only queues 1 and 6 occupied.
        cycle(1, 1, 4'd6, 48'hABCD_0000_1111, 8'h00);
        cycle(1, 6, 4'd1, 48'hFFFF_FFFF_FFFF, 8'h00);
        cycle(0, 0, 4'd0, 48'h0, 8'hFF);

        // Pointer wrap on queue 7 with single-entry occupancy.
        for (int k = 0; k < 10; k++) cycle(1, 7, 4'(k), AW'(48'h7000 + k), (k > 0) ? 8'h80 : 8'h00);
        cycle(0, 0, 4'd0, 48'h0, 8'h80);

        // Reset in the middle of traffic.
        cycle(1, 4, 4'd3, 48'h444, 8'h00);
        cycle(1, 5, 4'd3, 48'h555, 8'h00);
        do_reset();

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            a = {16'($urandom), $urandom};
            cycle($urandom_range(0, 9) < 8, int'($urandom_range(0, NP - 1)),
                  4'($urandom), a, 8'($urandom & $urandom));
        end
        for (int k = 0; k < DEPTH; k++) cycle(0, 0, 4'd0, 48'h0, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_request_injector.md
Name: bus_request_injector

Overview:
- Synthesizable per-processor request buffering stage directly upstream of the bus interconnect.
- Accepts cache-transfer requests from the socket/DPI front end, one per cycle.
- Queues them per source processor and presents each queue head to the bus as request_in_avail/request_dest/addrs_in.
- Retires a head when the bus asserts processed_request for that source; also tracks per-queue and total in-flight occupancy for logging.

Parameters:
NUM_PROC, 8, number of processors / queues
DEPTH, 4, entries per queue (>=2, any integer; wrap handled explicitly)
ADDR_W, 48, memory address width

Ports:
clk  input  1  interconnect clock
rst  input  1  synchronous active-high reset
enq_valid  input  1  new request offered this cycle
enq_src  input  $clog2(NUM_PROC)  source processor / target queue
enq_dest  input  $clog2(NUM_PROC)+1  destination processor
enq_addr  input  ADDR_W  request address
enq_ready  output  1  queue[enq_src] not full (count<DEPTH)
request_in_avail  output  NUM_PROC  queue i non-empty
request_dest  output  NUM_PROC x ($clog2(NUM_PROC)+1)  head dest of queue i
addrs_in  output  NUM_PROC x ADDR_W  head address of queue i
processed_request  input  NUM_PROC  bus consumed head of queue i
occupancy  output  NUM_PROC x ($clog2(DEPTH)+1)  entries in queue i
total_in_flight  output  $clog2(NUM_PROC*DEPTH)+1  sum of all occupancies
overflow_err  output  1  sticky: enqueue attempted while full
underflow_err  output  1  sticky: processed_request while empty

Behaviour:
- Clocking: one clock, clk; rst synchronous, active-high, all state updated on posedge clk.
- Reset:
  - all counts, read/write pointers, total_in_flight, overflow_err and underflow_err go to 0.
  - request_in_avail=0; request_dest and addrs_in read 0 (head outputs zero-masked when empty).
- Reset mid-operation: all queued entries are discarded. A processed_request or enq_valid in the reset cycle is ignored.
- Enqueue:
  - fires when enq_valid && enq_ready.
  - writes {enq_dest, enq_addr} at wptr[enq_src]; wptr increments and wraps DEPTH-1 -> 0.
- Enq_ready and overflow:
  - enq_ready depends on registered count only; a same-cycle pop does not free space.
  - enq_valid && !enq_ready: request dropped, no state change, overflow_err set (sticky until rst).
- Dequeue:
  - processed_request[i] with count[i]>0 advances rptr[i] (wrapping) and decrements count[i].
  - processed_request[i] with count[i]==0 is ignored and sets underflow_err (sticky).
- Simultaneous enqueue and pop on the same queue (non-full): both take effect; count unchanged; order preserved.
- Multiple pops per cycle are allowed, one per queue; only one enqueue per cycle.
- Latency:
  - an enqueue into an empty queue is visible on request_in_avail/head outputs the cycle after acceptance (1 cycle).
  - after a pop, the next head is presented the following cycle.
  - head outputs are held stable while request_in_avail=1 and no pop occurs.
- Output timing: request_in_avail/request_dest/addrs_in/occupancy are functions of registers only; no combinational path from processed_request or enq_* to them.
- total_in_flight:
  - registered; next = current + (enq fired) - popcount(valid pops).
  - must always equal the sum of occupancy; never wraps (max NUM_PROC*DEPTH).
- enq_dest: values >= NUM_PROC are passed through unmodified; range checking is the bus's job.

Decomposition:
- Shared package cadss_ic_pkg:
  - NUM_PROC default, ADDR_W default, PROC_W=$clog2(NUM_PROC), DEST_W=PROC_W+1.
  - packed request_t {dest[DEST_W], mem_address[ADDR_W]}.
  - The same package is shared with the bus and the completion side.
- Sub-module req_fifo:
  - single-queue FIFO with count/pointers, push, pop, head, underflow flag.
  - instantiated NUM_PROC times by a generate loop.
- The top level handles enq_src decode, enq_ready mux, total_in_flight and sticky errors.

Test Plan:
- Reset: rst=1 for 2 cycles with prior traffic -> all request_in_avail=0, occupancy=0, total_in_flight=0, errors=0, addrs_in=0.
- Basic: enqueue src=3 dest=5 addr=0x1000 -> next cycle request_in_avail=8'b0000_1000, request_dest[3]=5, addrs_in[3]=0x1000, total_in_flight=1. processed_request[3] -> next cycle avail[3]=0, total=0.
- Fill/overflow: 5 enqueues to src=0 (addrs 0x10..0x50), DEPTH=4 -> enq_ready=0 after 4th, 5th dropped, overflow_err=1, occupancy[0]=4. Pops yield 0x10,0x20,0x30,0x40 in order.
- Simultaneous: queue 2 holds 2 entries; enqueue src=2 addr=0xA and processed_request[2] same cycle -> occupancy[2] stays 2, total unchanged, 0xA eventually emerges last.
- Underflow and concurrency: processed_request=8'hFF with only queues 1 and 6 non-empty -> both pop, total decrements by 2, underflow_err=1.
- Wrap-around: 10 enqueue/pop pairs on src=7 with interleaved single-entry occupancy -> addresses emerge in exact enqueue order across pointer wrap, total_in_flight returns to 0.
